mem_arbiter: RTL

Two-requester round-robin arbiter and sequencer for the single-port synchronous memory block (registered read, one-cycle read latency, mutually exclusive rd/wr strobes). It accepts read/write transactions from two clients and serializes them onto the memory port. It sequences each access through a fixed-latency state machine and returns an ack pulse plus read data to the granted client. It sits between the two datapath clients and the memory instance.

---
 rtl/mem_arbiter_if.sv | 47 ++++
 rtl/mem_arbiter.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/mem_arbiter_if.sv
// Client request/ack bundle plus memory-side port of the two-client memory arbiter.
// Pure wiring: no logic, no latency of its own.
// Clients hold req until ack; no other backpressure exists on this bundle.
interface mem_arbiter_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
);
    // client 0
    logic                  req_0;
    logic                  wr_0;
    logic [ADDR_WIDTH-1:0] addr_0;
    logic [DATA_WIDTH-1:0] wdata_0;
    logic                  ack_0;
    // client 1
    logic                  req_1;
    logic                  wr_1;
    logic [ADDR_WIDTH-1:0] addr_1;
    logic [DATA_WIDTH-1:0] wdata_1;
    logic                  ack_1;
    // shared response / status
    logic [DATA_WIDTH-1:0] rdata;
    logic                  busy;
    // memory port
    logic                  mem_rd;
    logic                  mem_wr;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic [DATA_WIDTH-1:0] mem_rdata;

    // arbiter side: serves the clients, drives the memory
    modport slave (
        input  req_0, wr_0, addr_0, wdata_0,
        input  req_1, wr_1, addr_1, wdata_1,
        input  mem_rdata,
        output ack_0, ack_1, rdata, busy,
        output mem_rd, mem_wr, mem_addr, mem_wdata
    );

    // environment side: the two clients together with the memory instance
    modport master (
        output req_0, wr_0, addr_0, wdata_0,
        output req_1, wr_1, addr_1, wdata_1,
        output mem_rdata,
        input  ack_0, ack_1, rdata, busy,
        input  mem_rd, mem_wr, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter/sequencer putting two clients onto one single-port synchronous memory.
// Latency from the IDLE sampling edge: write ack in cycle +2, read ack with rdata in cycle +3.
// Clients hold req until their ack; requests are only looked at in IDLE, so a busy arbiter simply stalls them.
module mem_arbiter #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    mem_arbiter_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    state_t                state_q,      state_d;
    logic                  last_grant_q, last_grant_d;  // client served by the last contended grant
    logic                  gnt_q,        gnt_d;         // client owning the current transaction
    logic                  op_wr_q,      op_wr_d;       // latched direction of the current transaction
    logic                  mem_rd_q,     mem_rd_d;
    logic                  mem_wr_q,     mem_wr_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q,   mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_wdata_q,  mem_wdata_d;
    logic                  ack_0_q,      ack_0_d;
    logic                  ack_1_q,      ack_1_d;
    logic [DATA_WIDTH-1:0] rdata_q,      rdata_d;
    logic                  busy_q,       busy_d;

    logic                  any_req;
    logic                  contend;
    logic                  pick;        // client that would win if IDLE sampled now
    logic                  pick_wr;
    logic [ADDR_WIDTH-1:0] pick_addr;
    logic [DATA_WIDTH-1:0] pick_wdata;

    // Arbitration: a lone requester always wins; under contention the
    // client that did not win the previous contended grant goes first.
    always_comb begin
        any_req    = bus.req_0 | bus.req_1;
        contend    = bus.req_0 & bus.req_1;
        pick       = contend ? ~last_grant_q : bus.req_1;
        pick_wr    = pick ? bus.wr_1    : bus.wr_0;
        pick_addr  = pick ? bus.addr_1  : bus.addr_0;
        pick_wdata = pick ? bus.wdata_1 : bus.wdata_0;
    end

    // Next-state and registered-output computation for the access sequencer.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        gnt_d        = gnt_q;
        op_wr_d      = op_wr_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        rdata_d      = rdata_q;
        mem_rd_d     = 1'b0;
        mem_wr_d     = 1'b0;
        ack_0_d      = 1'b0;
        ack_1_d      = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (any_req) begin
                    gnt_d       = pick;
                    op_wr_d     = pick_wr;
                    mem_addr_d  = pick_addr;
                    mem_wdata_d = pick_wdata;
                    mem_wr_d    = pick_wr;
                    mem_rd_d    = ~pick_wr;
                    if (contend) begin
                        last_grant_d = pick;
                    end
                    state_d = ST_ACCESS;
                end
            end

            ST_ACCESS: begin
                // The memory acts on the edge closing this cycle. Writes are
                // finished then; reads still need the registered data phase.
                if (op_wr_q) begin
                    ack_0_d = ~gnt_q;
                    ack_1_d = gnt_q;
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_CAPTURE;
                end
            end

            ST_CAPTURE: begin
                rdata_d = bus.mem_rdata;
                ack_0_d = ~gnt_q;
                ack_1_d = gnt_q;
                state_d = ST_RESP;
            end

            ST_RESP: begin
                state_d = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers; an asynchronous reset aborts any transaction in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            gnt_q        <= 1'b0;
            op_wr_q      <= 1'b0;
            mem_rd_q     <= 1'b0;
            mem_wr_q     <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            ack_0_q      <= 1'b0;
            ack_1_q      <= 1'b0;
            rdata_q      <= '0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            gnt_q        <= gnt_d;
            op_wr_q      <= op_wr_d;
            mem_rd_q     <= mem_rd_d;
            mem_wr_q     <= mem_wr_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            ack_0_q      <= ack_0_d;
            ack_1_q      <= ack_1_d;
            rdata_q      <= rdata_d;
            busy_q       <= busy_d;
        end
    end

    assign bus.mem_rd    = mem_rd_q;
    assign bus.mem_wr    = mem_wr_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.ack_0     = ack_0_q;
    assign bus.ack_1     = ack_1_q;
    assign bus.rdata     = rdata_q;
    assign bus.busy      = busy_q;

endmodule
